// File: rtl/perf_pkg.sv
// Shared types and default sizes for the performance-counter unit.
package perf_pkg;

  localparam int unsigned PERF_CNT_W_DEF   = 32;
  localparam int unsigned PERF_NUM_CNT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_t;

endpackage

// File: rtl/perf_event_counter.sv
// One CNT_W-bit event counter with sticky overflow; wraps or saturates at all-ones.
module perf_event_counter
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = PERF_CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic             saturate_i,
  output logic [CNT_W-1:0] value_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] value_q, value_d;
  logic             ovf_q, ovf_d;

  // Next value: clear wins over increment; overflow is sticky until clear.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      value_d = '0;
      ovf_d   = 1'b0;
    end else if (inc_i) begin
      if (&value_q) begin
        value_d = saturate_i ? value_q : '0;
        ovf_d   = 1'b1;
      end else begin
        value_d = value_q + CNT_W'(1);
      end
    end
  end

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Pipeline performance monitor: cycle counter plus NUM_CNT event counters,
// start-gated FSM with optional cycle limit and a registered read port.
// Define PERF_SNAPSHOT_EN to build shadow registers loaded by snap_i and read back instead
// of the live counters.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CNT  = PERF_NUM_CNT_DEF,
  parameter int unsigned CNT_W    = PERF_CNT_W_DEF,
  parameter int unsigned LIMIT    = 0,
  parameter int unsigned SATURATE = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         clear_i,
  input  logic [NUM_CNT-1:0]           event_i,
  input  logic                         snap_i,
  input  logic [$clog2(NUM_CNT+1)-1:0] rd_sel_i,
  output logic [CNT_W-1:0]             rd_data_o,
  output logic [NUM_CNT:0]             ovf_o,
  output logic                         running_o,
  output logic                         done_o
);

  localparam int unsigned NumCntrs = NUM_CNT + 1;
  localparam int unsigned SelW     = $clog2(NUM_CNT + 1);
  // Only meaningful when LIMIT != 0.
  localparam logic [CNT_W-1:0] LimitLast = CNT_W'(LIMIT - 1);

  perf_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_val [NumCntrs];
  logic [CNT_W-1:0] rd_src  [NumCntrs];
  logic [NumCntrs-1:0] cnt_inc;
  logic [NumCntrs-1:0] cnt_ovf;
  logic                count_en;
  logic                limit_hit;
  logic [CNT_W-1:0]    rd_q, rd_d;

  assign limit_hit = (LIMIT != 0) && (cnt_val[0] == LimitLast);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; clear forces IDLE ahead of any transition.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i) state_d = RUN;
        RUN: begin
          if (!start_i)      state_d = IDLE;
          else if (limit_hit) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; the edge leaving RUN via start_i=0 counts nothing.
  always_comb begin
    count_en  = (state_q == RUN) && start_i;
    running_o = (state_q == RUN);
    done_o    = (state_q == DONE);
    cnt_inc   = {event_i & {NUM_CNT{count_en}}, count_en};
  end

  for (genvar g = 0; g < NumCntrs; g++) begin : g_cnt
    perf_event_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .inc_i      (cnt_inc[g]),
      .saturate_i (SATURATE != 0),
      .value_o    (cnt_val[g]),
      .ovf_o      (cnt_ovf[g])
    );
  end

  assign ovf_o = cnt_ovf;

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q [NumCntrs];

  // Shadow bank captures pre-edge live values; clear leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NumCntrs; i++) shadow_q[i] <= '0;
    end else if (snap_i) begin
      for (int i = 0; i < NumCntrs; i++) shadow_q[i] <= cnt_val[i];
    end
  end

  // Reads come from the shadow bank.
  always_comb begin
    for (int i = 0; i < NumCntrs; i++) rd_src[i] = shadow_q[i];
  end
`else
  logic unused_snap;
  assign unused_snap = snap_i;

  // Reads come straight from the live counters.
  always_comb begin
    for (int i = 0; i < NumCntrs; i++) rd_src[i] = cnt_val[i];
  end
`endif

  // Read mux; selects above NUM_CNT fall through to zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NumCntrs; i++) begin
      if (rd_sel_i == SelW'(i)) rd_d = rd_src[i];
    end
  end

  // Registered read data.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data_o = rd_q;

endmodule
